// File: rtl/burst_pkg.sv
// Shared constants and types for the cache-line burst responder.
//   LINE_W   : cache line width in bits
//   BEAT_W   : memory beat width in bits
//   ADDR_W   : byte address width
//   BEATS    : beats per line
//   OFFSET_W : byte-offset bits inside one line
//   CNT_W    : width of the beat counter
//   ALIGN_MASK : clears the byte-offset bits of an address
package burst_pkg;

  localparam int LINE_W   = 256;
  localparam int BEAT_W   = 64;
  localparam int ADDR_W   = 32;
  localparam int BEATS    = LINE_W / BEAT_W;
  localparam int OFFSET_W = $clog2(LINE_W / 8);
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << OFFSET_W) - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } burst_state_t;

endpackage

// File: rtl/cacheline_burst_responder_if.sv
// Bundle of the cache-side (pmem_*) and memory-side (mem_*) signals of the
// burst responder.
//   slave  : the responder's view (takes pmem requests and mem beats,
//            drives the pmem completion and the mem burst)
//   master : the environment's view (cache controller plus memory model)
interface cacheline_burst_responder_if;
  import burst_pkg::*;

  // cache side
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  // memory side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [BEAT_W-1:0] mem_wdata;
  logic [BEAT_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, mem_rdata, mem_resp,
    output pmem_rdata, pmem_resp, mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata, mem_rdata, mem_resp,
    input  pmem_rdata, pmem_resp, mem_read, mem_write, mem_address, mem_wdata
  );

endinterface

// File: rtl/line_beat_buffer.sv
// One cache line of storage, loaded either as a whole line (write requests)
// or one beat at a time (read bursts).
//   clk, rst   : clock, asynchronous active-low reset
//   load_line  : load line_in into the whole buffer (wins over beat_we)
//   line_in    : full line to load
//   beat_we    : write beat_in into beat slot beat_idx
//   beat_idx   : beat slot for both the write and the read port
//   beat_in    : beat to write
//   beat_out   : beat slot beat_idx of the buffer
//   line_out   : whole buffer
module line_beat_buffer
  import burst_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_line,
  input  logic [LINE_W-1:0] line_in,
  input  logic              beat_we,
  input  logic [CNT_W-1:0]  beat_idx,
  input  logic [BEAT_W-1:0] beat_in,
  output logic [BEAT_W-1:0] beat_out,
  output logic [LINE_W-1:0] line_out
);

  logic [LINE_W-1:0] line_q, line_d;

  always_comb begin
    // NOTE: assigning the hold value first means every path assigns line_d,
    // so no latch is inferred.
    line_d = line_q;
    if (load_line) begin
      line_d = line_in;
    end else if (beat_we) begin
      line_d[beat_idx*BEAT_W +: BEAT_W] = beat_in;
    end
  end

  // NOTE: this line store is a flop array, not a RAM macro, so it is reset;
  // pmem_rdata must read as zero after reset and a discarded partial line
  // must not leak into the next transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign beat_out = line_q[beat_idx*BEAT_W +: BEAT_W];
  assign line_out = line_q;

endmodule

// File: rtl/cacheline_burst_responder.sv
// Memory-side responder for the cache's line interface. A line read is
// performed as BEATS memory read beats assembled into one line; a line write
// is split into BEATS memory write beats. A one-cycle pmem_resp follows the
// last beat. All outputs decode from registered state.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave view of the pmem_* / mem_* signal bundle
module cacheline_burst_responder
  import burst_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  cacheline_burst_responder_if.slave  bus
);

  burst_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              load_line;
  logic              beat_we;
  logic              last_beat;
  logic [BEAT_W-1:0] beat_rd;
  logic [LINE_W-1:0] line_rd;

  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    load_line = 1'b0;
    beat_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Write has priority; a simultaneous read waits for a later IDLE cycle.
        if (bus.pmem_write) begin
          addr_d    = bus.pmem_address & ALIGN_MASK;
          cnt_d     = '0;
          load_line = 1'b1;
          state_d   = WR_BURST;
        end else if (bus.pmem_read) begin
          addr_d  = bus.pmem_address & ALIGN_MASK;
          cnt_d   = '0;
          state_d = RD_BURST;
        end
      end
      WR_BURST: begin
        if (bus.mem_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      RD_BURST: begin
        if (bus.mem_resp) begin
          beat_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      // The request is deliberately not sampled here, so a request still held
      // while pmem_resp pulses cannot chain straight into a new burst.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  line_beat_buffer u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .load_line (load_line),
    .line_in   (bus.pmem_wdata),
    .beat_we   (beat_we),
    .beat_idx  (cnt_q),
    .beat_in   (bus.mem_rdata),
    .beat_out  (beat_rd),
    .line_out  (line_rd)
  );

  assign bus.mem_read    = (state_q == RD_BURST);
  assign bus.mem_write   = (state_q == WR_BURST);
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = (state_q == WR_BURST) ? beat_rd : '0;
  assign bus.pmem_resp   = (state_q == DONE);
  assign bus.pmem_rdata  = line_rd;

endmodule

// File: tb/tb_cacheline_burst_responder.sv
// Self-checking bench for cacheline_burst_responder. A transaction-level model
// (which transfer is in flight, how many beats are done, what the line buffer
// holds) plus a sparse memory model are compared with the DUT on every
// falling edge; directed scenarios add literal expectations.
module tb_cacheline_burst_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_burst_responder_if bus ();

  cacheline_burst_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // bookkeeping
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int resp_seen_cyc = 0;
  int r_hs = 0;
  int w_hs = 0;
  int w_cycles = 0;
  logic [31:0] last_busy_addr = '0;
  logic [63:0] wbeat_q[$];

  // stimulus controls: 0 = mem_resp tied high, 1 = random, 2 = pattern queue
  int resp_mode = 0;
  bit pat_q[$];
  logic        nxt_read = 1'b0;
  logic        nxt_write = 1'b0;
  logic [31:0] nxt_addr = '0;
  logic [255:0] nxt_wdata = '0;

  // transaction model: kind 0 none, 1 line read, 2 line write
  int           m_kind = 0;
  int           m_beats = 0;
  bit           m_resp_due = 1'b0;
  logic [31:0]  m_addr = '0;
  logic [255:0] m_buf = '0;

  // sparse physical memory, one entry per aligned line
  logic [255:0] mem_store[logic [31:0]];

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return {a, 32'hBEA7_0003, a, 32'hBEA7_0002, a, 32'hBEA7_0001, a, 32'hBEA7_0000};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pmem_resp"},   256'(bus.pmem_resp),   256'(0));
    check({tag, "_mem_read"},    256'(bus.mem_read),    256'(0));
    check({tag, "_mem_write"},   256'(bus.mem_write),   256'(0));
    check({tag, "_mem_address"}, 256'(bus.mem_address), 256'(0));
    check({tag, "_mem_wdata"},   256'(bus.mem_wdata),   256'(0));
    check({tag, "_pmem_rdata"},  bus.pmem_rdata,        256'(0));
  endtask

  // One clock: compare at the falling edge, then drive inputs for the next
  // rising edge and advance the model to what that edge must do.
  task automatic tick();
    bit           resp;
    logic [255:0] line;
    @(negedge clk);
    cyc++;
    check("mem_read",    256'(bus.mem_read),  256'(m_kind == 1));
    check("mem_write",   256'(bus.mem_write), 256'(m_kind == 2));
    check("rd_wr_excl",  256'(bus.mem_read & bus.mem_write), 256'(0));
    check("pmem_resp",   256'(bus.pmem_resp), 256'(m_resp_due));
    check("mem_address", 256'(bus.mem_address), 256'(m_addr));
    check("pmem_rdata",  bus.pmem_rdata, m_buf);
    if (m_kind == 2) begin
      line = m_buf;
      check("mem_wdata", 256'(bus.mem_wdata), 256'(line[m_beats*64 +: 64]));
    end
    if (bus.pmem_resp) begin
      resp_cnt++;
      resp_seen_cyc = cyc;
    end
    if (bus.mem_read || bus.mem_write) last_busy_addr = bus.mem_address;
    if (bus.mem_write) w_cycles++;

    case (resp_mode)
      0:       resp = 1'b1;
      1:       resp = ($urandom_range(0, 9) < 6);
      default: begin
        if (bus.mem_read || bus.mem_write) resp = (pat_q.size() > 0) ? pat_q.pop_front() : 1'b1;
        else resp = 1'b0;
      end
    endcase
    bus.mem_resp = resp;
    if (bus.mem_read && resp) begin
      line = mem_line(bus.mem_address);
      bus.mem_rdata = line[m_beats*64 +: 64];
    end else begin
      bus.mem_rdata = {$urandom, $urandom};
    end
    bus.pmem_read    = nxt_read;
    bus.pmem_write   = nxt_write;
    bus.pmem_address = nxt_addr;
    bus.pmem_wdata   = nxt_wdata;

    if (m_resp_due) begin
      m_resp_due = 1'b0;
    end else if (m_kind == 0) begin
      if (nxt_write) begin
        m_kind = 2; m_addr = nxt_addr & 32'hFFFF_FFE0; m_buf = nxt_wdata; m_beats = 0;
      end else if (nxt_read) begin
        m_kind = 1; m_addr = nxt_addr & 32'hFFFF_FFE0; m_beats = 0;
      end
    end else if (resp) begin
      if (m_kind == 1) begin
        m_buf[m_beats*64 +: 64] = bus.mem_rdata;
        r_hs++;
      end else begin
        line = mem_line(m_addr);
        line[m_beats*64 +: 64] = bus.mem_wdata;
        mem_store[m_addr] = line;
        wbeat_q.push_back(bus.mem_wdata);
        w_hs++;
      end
      m_beats++;
      if (m_beats == 4) begin
        m_kind = 0; m_beats = 0; m_resp_due = 1'b1;
      end
    end
  endtask

  task automatic wait_resp(input int budget);
    int start;
    start = resp_cnt;
    for (int i = 0; i < budget && resp_cnt == start; i++) tick();
    check("resp_timeout", 256'(resp_cnt != start), 256'(1));
  endtask

  // Issue one line request, hold it until pmem_resp (or drop it early),
  // and report cycles from the cycle the request is first seen to pmem_resp.
  task automatic do_txn(input bit wr, input logic [31:0] a, input logic [255:0] wd,
                        input bit drop, output int lat);
    int start;
    nxt_write = wr; nxt_read = !wr; nxt_addr = a; nxt_wdata = wd;
    tick();
    start = cyc;
    if (drop) begin
      tick();
      nxt_read = 1'b0; nxt_write = 1'b0;
    end
    wait_resp(300);
    lat = resp_seen_cyc - start;
    nxt_read = 1'b0; nxt_write = 1'b0;
  endtask

  task automatic async_reset_now();
    rst = 1'b0;
    #1;
    check_outputs_zero("midrst");
    m_kind = 0; m_beats = 0; m_resp_due = 1'b0; m_addr = '0; m_buf = '0;
    nxt_read = 1'b0; nxt_write = 1'b0;
    bus.pmem_read = 1'b0; bus.pmem_write = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    int           lat;
    int           r0;
    logic [255:0] wline;
    logic [255:0] wd;
    logic [63:0]  exp_w[4];
    logic [31:0]  a;

    rst = 1'b0;
    bus.pmem_read = 1'b0; bus.pmem_write = 1'b0; bus.pmem_address = '0;
    bus.pmem_wdata = '0; bus.mem_rdata = '0; bus.mem_resp = 1'b0;
    #2;
    check_outputs_zero("reset");
    @(negedge clk);
    #2 rst = 1'b1;
    tick();

    // read, mem_resp tied high: aligned address, beat order, 5-cycle latency
    mem_store[32'h0000_1220] = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
    resp_mode = 0;
    do_txn(1'b0, 32'h0000_1234, '0, 1'b0, lat);
    check("t1_latency", 256'(lat), 256'(5));
    check("t1_mem_address", 256'(last_busy_addr), 256'(32'h0000_1220));
    check("t1_rdata", bus.pmem_rdata,
          {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}});
    tick(); tick();

    // write: beats leave low beat first, mem_write held exactly 4 cycles
    wline = {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}};
    exp_w = '{{4{16'hAAAA}}, {4{16'hBBBB}}, {4{16'hCCCC}}, {4{16'hDDDD}}};
    wbeat_q.delete(); w_cycles = 0; r0 = resp_cnt;
    do_txn(1'b1, 32'h0000_4000, wline, 1'b0, lat);
    tick(); tick(); tick();
    check("t2_latency", 256'(lat), 256'(5));
    check("t2_beat_count", 256'(wbeat_q.size()), 256'(4));
    for (int i = 0; i < 4; i++)
      check($sformatf("t2_beat%0d", i), 256'((wbeat_q.size() > i) ? wbeat_q[i] : 64'hx), 256'(exp_w[i]));
    check("t2_write_cycles", 256'(w_cycles), 256'(4));
    check("t2_resp_count", 256'(resp_cnt - r0), 256'(1));

    // read with gapped mem_resp 1,0,0,1,0,1,1
    mem_store[32'h0000_8000] = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0};
    resp_mode = 2; pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}; r_hs = 0;
    do_txn(1'b0, 32'h0000_8010, '0, 1'b0, lat);
    check("t3_latency", 256'(lat), 256'(8));
    check("t3_beats", 256'(r_hs), 256'(4));
    check("t3_rdata", bus.pmem_rdata,
          {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
           64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0});
    tick(); tick();

    // read and write together: write burst first, then the read returns it
    resp_mode = 1; r_hs = 0; w_hs = 0;
    wline = {64'hC0DE_0000_0000_0004, 64'hC0DE_0000_0000_0003,
             64'hC0DE_0000_0000_0002, 64'hC0DE_0000_0000_0001};
    nxt_write = 1'b1; nxt_read = 1'b1; nxt_addr = 32'h0000_C008; nxt_wdata = wline;
    wait_resp(300);
    check("t4_write_first_w", 256'(w_hs), 256'(4));
    check("t4_write_first_r", 256'(r_hs), 256'(0));
    nxt_write = 1'b0;
    wait_resp(300);
    nxt_read = 1'b0;
    check("t4_read_after_r", 256'(r_hs), 256'(4));
    check("t4_read_data", bus.pmem_rdata, wline);
    tick(); tick();

    // reset during beat 2 of a read, then a clean read from beat 0
    resp_mode = 0;
    nxt_read = 1'b1; nxt_addr = 32'h0000_2000;
    tick(); tick(); tick(); tick();
    async_reset_now();
    do_txn(1'b0, 32'h0000_2000, '0, 1'b0, lat);
    check("t5_latency", 256'(lat), 256'(5));
    check("t5_rdata", bus.pmem_rdata, mem_line(32'h0000_2000));
    tick();

    // request held past pmem_resp: DONE returns to IDLE without a burst
    nxt_read = 1'b1; nxt_addr = 32'h0000_3000;
    wait_resp(50);
    tick();
    check("t6_idle_after_done", 256'(bus.mem_read), 256'(0));
    tick(); tick();
    nxt_read = 1'b0;
    wait_resp(50);
    tick(); tick();

    // randomized traffic over a few lines, occasional early request drop
    resp_mode = 1;
    for (int t = 0; t < 40; t++) begin
      a = 32'h0001_0000 | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
      for (int i = 0; i < 8; i++) wd[i*32 +: 32] = $urandom;
      do_txn(1'($urandom_range(0, 1)), a, wd, ($urandom_range(0, 7) == 0), lat);
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick();
    end
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
